// File: rtl/serial_receiver_pkg.sv
// Shared constants for the one-bit-per-clock serial link (receiver and transmitter).
package serial_receiver_pkg;

  typedef enum logic [1:0] {
    StResync = 2'd0,
    StIdle   = 2'd1,
    StData   = 2'd2,
    StStop   = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/serial_receiver_if.sv
// Receiver-side bundle: serial line in, valid/ready word out, error flags.
interface serial_receiver_if #(
  parameter int unsigned DATA_W = 8
);
  logic              rxd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  // Receiver side
  modport slave (
    input  rxd,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy
  );

  // Line driver / consumer side
  modport master (
    output rxd,
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/serial_receiver_bit_sync.sv
// Two-flop synchronizer for a single bit, reset to 0.
module serial_receiver_bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/serial_receiver.sv
// Serial link receiver: start bit 1, DATA_W data bits LSB first, stop bit 0.
// Optional macro RXD_SYNC_EN inserts a 2-flop synchronizer on rxd (+2 cycles latency).
module serial_receiver #(
  parameter int unsigned DATA_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_receiver_if.slave bus
);
  import serial_receiver_pkg::*;

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  rx_state_e         r_state;
  logic [CntW-1:0]   r_bit_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;
  logic              r_overrun;
  logic              w_bit;
  logic              w_good;
  logic              w_bad;

`ifdef RXD_SYNC_EN
  serial_receiver_bit_sync u_bit_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.rxd),
    .o_q   (w_bit)
  );
`else
  assign w_bit = bus.rxd;
`endif

  // Stop-bit outcome; the shift register already holds the full word in StStop
  assign w_good = (r_state == StStop) && (w_bit == STOP_BIT);
  assign w_bad  = (r_state == StStop) && (w_bit != STOP_BIT);

  // Frame FSM and data shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StResync;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else begin
      case (r_state)
        // Wait for the idle level so a mid-frame reset/error cannot fake a start bit
        StResync: if (w_bit == IDLE_LVL) r_state <= StIdle;
        StIdle: begin
          if (w_bit == START_BIT) begin
            r_state   <= StData;
            r_bit_cnt <= '0;
          end
        end
        StData: begin
          r_shreg[r_bit_cnt] <= w_bit;
          if (r_bit_cnt == LastCnt) r_state <= StStop;
          else                      r_bit_cnt <= r_bit_cnt + CntW'(1);
        end
        StStop:   r_state <= w_good ? StIdle : StResync;
        default:  r_state <= StResync;
      endcase
    end
  end

  // Output word register with valid/ready handshake, plus one-cycle error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      r_overrun   <= 1'b0;
      if (w_good) begin
        if (!r_rx_valid || bus.rx_ready) begin
          r_rx_data  <= r_shreg;
          r_rx_valid <= 1'b1;
        end else begin
          // Consumer stalled: keep the old word, drop the new one
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver; expected words queued by stimulus, popped by monitor.
module tb_serial_receiver;

`ifdef RXD_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   err_cnt;
  int   ovr_cnt;
  int   e0;
  int   o0;
  logic [7:0] exp_q[$];

  serial_receiver_if #(.DATA_W(8)) bus ();

  serial_receiver #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.rxd = b;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bit(1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  // Monitor: count pulses, compare each transferred word against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err) err_cnt++;
      if (bus.overrun) ovr_cnt++;
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got %0h want none", bus.rx_data);
        end else begin
          check("rx_data", {24'h0, bus.rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; err_cnt = 0; ovr_cnt = 0;
    bus.rxd = 1'b0; bus.rx_ready = 1'b1; rst_n = 1'b0;
    repeat (2) tick();
    check("rst_valid", bus.rx_valid, 0);
    check("rst_data", bus.rx_data, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovr", bus.overrun, 0);
    check("rst_busy", bus.busy, 1);
    rst_n = 1'b1;
    idle(4 + Lat);
    check("idle_busy", bus.busy, 0);

    // 1: single frame A5, exact latency
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0);
    repeat (Lat) tick();
    check("t1_valid", bus.rx_valid, 1);
    check("t1_data", bus.rx_data, 8'hA5);
    tick();
    check("t1_valid_clr", bus.rx_valid, 0);
    idle(4);
    check("t1_drained", exp_q.size(), 0);

    // 2: back-to-back 3C, C3
    e0 = err_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b0);
    send_frame(8'hC3, 1'b0);
    idle(4 + Lat);
    check("t2_drained", exp_q.size(), 0);
    check("t2_ferr", err_cnt - e0, 0);
    check("t2_ovr", ovr_cnt - o0, 0);

    // 3: framing error, resync, then good frame 81
    e0 = err_cnt;
    send_frame(8'h5A, 1'b1);
    repeat (3) drive_bit(1'b1);
    check("t3_ferr", err_cnt - e0, 1);
    check("t3_novalid", bus.rx_valid, 0);
    check("t3_busy_hold", bus.busy, 1);
    repeat (Lat + 1) drive_bit(1'b0);
    check("t3_busy_clr", bus.busy, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0);
    idle(4 + Lat);
    check("t3_drained", exp_q.size(), 0);

    // 4: stalled consumer, overrun on second frame
    o0 = ovr_cnt; e0 = err_cnt;
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    idle(4 + Lat);
    check("t4_valid", bus.rx_valid, 1);
    check("t4_data_held", bus.rx_data, 8'h11);
    check("t4_ovr", ovr_cnt - o0, 1);
    check("t4_ferr", err_cnt - e0, 0);
    bus.rx_ready = 1'b1;
    tick();
    check("t4_valid_clr", bus.rx_valid, 0);
    check("t4_drained", exp_q.size(), 0);

    // 5: new word completes on the same edge the old one transfers
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b0);
    idle(4 + Lat);
    check("t5_old_data", bus.rx_data, 8'h44);
    exp_q.push_back(8'h55);
    o0 = ovr_cnt;
    drive_bit(1'b1);
    for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1);  // 0x55 LSB first
    bus.rxd = 1'b0;
    repeat (Lat) tick();
    bus.rx_ready = 1'b1;
    tick();
    check("t5_valid", bus.rx_valid, 1);
    check("t5_new_data", bus.rx_data, 8'h55);
    check("t5_ovr", ovr_cnt - o0, 0);
    check("t5_pending", exp_q.size(), 1);
    tick();
    check("t5_valid_clr", bus.rx_valid, 0);
    check("t5_drained", exp_q.size(), 0);

    // 6: reset mid-DATA of FF with a word pending
    bus.rx_ready = 1'b0;
    send_frame(8'h66, 1'b0);
    idle(4 + Lat);
    check("t6_pre_valid", bus.rx_valid, 1);
    repeat (5) drive_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.rx_valid, 0);
    check("t6_rst_data", bus.rx_data, 0);
    check("t6_rst_ferr", bus.frame_err, 0);
    check("t6_rst_ovr", bus.overrun, 0);
    check("t6_rst_busy", bus.busy, 1);
    tick();
    rst_n = 1'b1;
    e0 = err_cnt;
    repeat (14) drive_bit(1'b1);
    // Synchronizer resets to 0, so the sync build sees one bogus all-ones frame
    check("t6_hold_ferr", err_cnt - e0, (Lat == 2) ? 1 : 0);
    check("t6_hold_busy", bus.busy, 1);
    check("t6_hold_valid", bus.rx_valid, 0);
    bus.rx_ready = 1'b1;
    repeat (Lat + 1) drive_bit(1'b0);
    check("t6_busy_clr", bus.busy, 0);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b0);
    idle(4 + Lat);
    check("t6_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
